// File: rtl/svm_ctrl.sv
// svm_ctrl: sequences the SVM SRAM/intercept load, then issues valence and
// arousal feature vectors in order and holds each SVM result for the host.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cfg_valid/ready/icpt/last      host config beats
//   svm_mem_we/write_addr          SVM row write strobe and address
//   svm_intercept_valid            SVM intercept capture strobe
//   svm_mem_write_done             one-cycle end-of-load pulse
//   svm_mem_write_ready            SVM is in its SRAM-write state
//   v_feat_*, a_feat_*             valence / arousal feature handshakes
//   svm_fin_valid/ready, features  muxed SVM feature port
//   svm_dout_valid/valence/arousal SVM result pulse
//   res_valid/ready/valence/arousal held, handshaked result
//   res_count                      completed inferences (wraps)
//   busy, cfg_err, timeout_err     status and sticky error flags
module svm_ctrl #(
  parameter int NBITS   = 9,
  parameter int F_WIDTH = 214,
  parameter int NROWS   = 214,
  parameter int TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic                     cfg_icpt,
  input  logic                     cfg_last,
  input  logic                     svm_mem_write_ready,
  output logic                     svm_mem_we,
  output logic [7:0]               svm_mem_write_addr,
  output logic                     svm_intercept_valid,
  output logic                     svm_mem_write_done,
  input  logic                     v_feat_valid,
  output logic                     v_feat_ready,
  input  logic [NBITS*F_WIDTH-1:0] v_feat_data,
  input  logic                     a_feat_valid,
  output logic                     a_feat_ready,
  input  logic [NBITS*F_WIDTH-1:0] a_feat_data,
  output logic                     svm_fin_valid,
  input  logic                     svm_fin_ready,
  output logic [NBITS*F_WIDTH-1:0] svm_features,
  input  logic                     svm_dout_valid,
  input  logic                     svm_valence,
  input  logic                     svm_arousal,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     res_valence,
  output logic                     res_arousal,
  output logic [15:0]              res_count,
  output logic                     busy,
  output logic                     cfg_err,
  output logic                     timeout_err
);

  localparam logic [15:0] NR = 16'(NROWS);
  localparam logic [15:0] TO = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    LOAD, DONE, V_ISSUE, A_ISSUE, WAIT_RES, OUT
  } state_t;

  state_t      state;
  logic [15:0] row_cnt;
  logic [15:0] wd;
  logic [15:0] rows_incl;
  logic        cfg_fire;
  logic        v_sel;
  logic        a_sel;

  always_comb begin
    v_sel     = (state == V_ISSUE);
    a_sel     = (state == A_ISSUE);
    cfg_ready = (state == LOAD) && svm_mem_write_ready;
    cfg_fire  = cfg_valid && cfg_ready;
    svm_mem_we          = cfg_fire && !cfg_icpt;
    svm_intercept_valid = cfg_fire && cfg_icpt;
    // address is the low byte of the row counter, so it wraps past 255
    svm_mem_write_addr  = row_cnt[7:0];
    svm_mem_write_done  = (state == DONE);
    rows_incl    = row_cnt + {15'd0, !cfg_icpt};
    svm_fin_valid = (v_sel && v_feat_valid) || (a_sel && a_feat_valid);
    v_feat_ready = v_sel && svm_fin_ready;
    a_feat_ready = a_sel && svm_fin_ready;
    svm_features = '0;
    if (v_sel) svm_features = v_feat_data;
    if (a_sel) svm_features = a_feat_data;
    busy = (state != V_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      row_cnt     <= '0;
      wd          <= '0;
      res_valid   <= 1'b0;
      res_valence <= 1'b0;
      res_arousal <= 1'b0;
      res_count   <= '0;
      cfg_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (cfg_fire) begin
            row_cnt <= rows_incl;
            if (cfg_last) begin
              if (rows_incl != NR) cfg_err <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: state <= V_ISSUE;
        V_ISSUE: begin
          if (v_feat_valid && svm_fin_ready) state <= A_ISSUE;
        end
        A_ISSUE: begin
          if (a_feat_valid && svm_fin_ready) begin
            wd    <= '0;
            state <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          // watchdog saturates; a late result is still accepted
          if (wd != TO) wd <= wd + 16'd1;
          if (wd == TO - 16'd1) timeout_err <= 1'b1;
          if (svm_dout_valid) begin
            res_valence <= svm_valence;
            res_arousal <= svm_arousal;
            res_valid   <= 1'b1;
            res_count   <= res_count + 16'd1;
            state       <= OUT;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= V_ISSUE;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_svm_ctrl.sv
// tb_svm_ctrl: randomized scoreboard bench for svm_ctrl.
// Expected writes, features and results are queued; a monitor pops them.
module tb_svm_ctrl;

  localparam int NBITS = 9;
  localparam int FW_N  = 214;
  localparam int NROWS = 214;
  localparam int TOUT  = 50;
  localparam int W     = NBITS * FW_N;

  logic clk = 0;
  logic rst = 1;
  logic cfg_valid = 0, cfg_ready, cfg_icpt = 0, cfg_last = 0;
  logic svm_mem_write_ready = 1;
  logic svm_mem_we, svm_intercept_valid, svm_mem_write_done;
  logic [7:0] svm_mem_write_addr;
  logic v_feat_valid = 0, v_feat_ready;
  logic a_feat_valid = 0, a_feat_ready;
  logic [W-1:0] v_feat_data = '0, a_feat_data = '0, svm_features;
  logic svm_fin_valid, svm_fin_ready = 1;
  logic svm_dout_valid = 0, svm_valence = 0, svm_arousal = 0;
  logic res_valid, res_ready = 1, res_valence, res_arousal;
  logic [15:0] res_count;
  logic busy, cfg_err, timeout_err;

  svm_ctrl #(.NBITS(NBITS), .F_WIDTH(FW_N), .NROWS(NROWS), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_icpt(cfg_icpt), .cfg_last(cfg_last),
    .svm_mem_write_ready(svm_mem_write_ready),
    .svm_mem_we(svm_mem_we), .svm_mem_write_addr(svm_mem_write_addr),
    .svm_intercept_valid(svm_intercept_valid),
    .svm_mem_write_done(svm_mem_write_done),
    .v_feat_valid(v_feat_valid), .v_feat_ready(v_feat_ready),
    .v_feat_data(v_feat_data),
    .a_feat_valid(a_feat_valid), .a_feat_ready(a_feat_ready),
    .a_feat_data(a_feat_data),
    .svm_fin_valid(svm_fin_valid), .svm_fin_ready(svm_fin_ready),
    .svm_features(svm_features),
    .svm_dout_valid(svm_dout_valid), .svm_valence(svm_valence),
    .svm_arousal(svm_arousal),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_valence(res_valence), .res_arousal(res_arousal),
    .res_count(res_count), .busy(busy),
    .cfg_err(cfg_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_addr_q[$];
  logic [W-1:0] exp_feat_q[$];
  logic [17:0] exp_res_q[$];
  int icpt_seen = 0;
  int done_seen = 0;
  int model_count = 0;
  bit exp_to = 0;
  bit stall_en = 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // random backpressure from the SVM side
  initial forever begin
    @(posedge clk); #1;
    if (stall_en) begin
      svm_mem_write_ready = ($urandom_range(3) != 0);
      svm_fin_ready = ($urandom_range(3) != 0);
    end else begin
      svm_mem_write_ready = 1;
      svm_fin_ready = 1;
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (svm_mem_we) begin
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_we: unexpected write addr %0h", svm_mem_write_addr);
        end else begin
          int e;
          e = exp_addr_q.pop_front();
          chk("write_addr", 32'(svm_mem_write_addr), 32'(e[7:0]));
          chk("we_on_fire", 32'(cfg_valid && cfg_ready), 32'd1);
        end
      end
      if (svm_intercept_valid) icpt_seen++;
      if (svm_mem_write_done) done_seen++;
      if (svm_fin_valid && svm_fin_ready) begin
        checks++;
        if (exp_feat_q.size() == 0) begin
          errors++;
          $display("FAIL fin_fire: unexpected feature issue");
        end else begin
          logic [W-1:0] f;
          f = exp_feat_q.pop_front();
          if (svm_features !== f) begin
            errors++;
            $display("FAIL features: got %0h expected %0h",
                     svm_features[31:0], f[31:0]);
          end
        end
      end
      if (res_valid && res_ready) begin
        if (exp_res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL res: unexpected result");
        end else begin
          logic [17:0] r;
          r = exp_res_q.pop_front();
          chk("res_valence", 32'(res_valence), 32'(r[17]));
          chk("res_arousal", 32'(res_arousal), 32'(r[16]));
          chk("res_count", 32'(res_count), 32'(r[15:0]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_fire(input int which, input string nm);
    int n;
    bit got;
    n = 0;
    got = 0;
    while (!got && n < 1000) begin
      @(negedge clk);
      case (which)
        0: got = cfg_valid && cfg_ready;
        1: got = v_feat_ready;
        default: got = a_feat_ready;
      endcase
      n++;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s: handshake never completed", nm);
    end
    tick();
  endtask

  task automatic cfg_beat(input bit icpt, input bit last, input int row);
    if (!icpt) exp_addr_q.push_back(row);
    cfg_valid = 1;
    cfg_icpt = icpt;
    cfg_last = last;
    wait_fire(0, "cfg_fire");
    cfg_valid = 0;
    cfg_icpt = 0;
    cfg_last = 0;
  endtask

  task automatic do_load(input int last_row);
    icpt_seen = 0;
    done_seen = 0;
    cfg_beat(1, 0, 0);
    for (int r = 0; r <= last_row; r++) cfg_beat(0, r == last_row, r);
    @(negedge clk);
    chk("done_t1", 32'(svm_mem_write_done), 32'd1);
    chk("cfg_ready_done", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    chk("done_t2", 32'(svm_mem_write_done), 32'd0);
    chk("in_v_issue", 32'(busy), 32'd0);
    chk("icpt_count", 32'(icpt_seen), 32'd1);
    chk("done_count", 32'(done_seen), 32'd1);
    chk("writes_left", 32'(exp_addr_q.size()), 32'd0);
    chk("cfg_err", 32'(cfg_err), 32'(last_row + 1 != NROWS));
    tick();
  endtask

  task automatic rand_vec(output logic [W-1:0] d);
    for (int i = 0; i < W; i++) d[i] = 1'($urandom_range(1));
  endtask

  task automatic issue(input bit a_first);
    logic [W-1:0] vd, ad;
    rand_vec(vd);
    rand_vec(ad);
    exp_feat_q.push_back(vd);
    exp_feat_q.push_back(ad);
    if (a_first) begin
      a_feat_data = ad;
      a_feat_valid = 1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("a_ready_gated", 32'(a_feat_ready), 32'd0);
        chk("no_fin_early", 32'(svm_fin_valid), 32'd0);
        tick();
      end
    end
    v_feat_data = vd;
    v_feat_valid = 1;
    wait_fire(1, "v_fire");
    v_feat_valid = 0;
    a_feat_data = ad;
    a_feat_valid = 1;
    wait_fire(2, "a_fire");
    a_feat_valid = 0;
  endtask

  task automatic respond(input int delay, input int hold, input bit to_chk);
    bit val, aro;
    val = 1'($urandom_range(1));
    aro = 1'($urandom_range(1));
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      chk("no_early_res", 32'(res_valid), 32'd0);
      if (to_chk && k == TOUT - 1) chk("to_before", 32'(timeout_err), 32'd0);
      if (to_chk && k == TOUT) chk("to_at", 32'(timeout_err), 32'd1);
      tick();
    end
    if (delay >= TOUT) exp_to = 1;
    res_ready = (hold == 0);
    svm_dout_valid = 1;
    svm_valence = val;
    svm_arousal = aro;
    model_count = (model_count + 1) % 65536;
    exp_res_q.push_back({val, aro, 16'(model_count)});
    tick();
    svm_dout_valid = 0;
    svm_valence = 0;
    svm_arousal = 0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_val", 32'(res_valence), 32'(val));
      chk("hold_aro", 32'(res_arousal), 32'(aro));
      chk("hold_v_ready", 32'(v_feat_ready), 32'd0);
      tick();
    end
    res_ready = 1;
    tick();
    @(negedge clk);
    chk("res_dropped", 32'(res_valid), 32'd0);
    chk("back_v_issue", 32'(busy), 32'd0);
    chk("timeout_err", 32'(timeout_err), 32'(exp_to));
    tick();
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_bits", 32'({res_valence, res_arousal}), 32'd0);
    chk("rst_res_count", 32'(res_count), 32'd0);
    chk("rst_errs", 32'({cfg_err, timeout_err}), 32'd0);
    chk("rst_addr", 32'(svm_mem_write_addr), 32'd0);
    chk("rst_strobes", 32'({svm_mem_we, svm_intercept_valid,
                            svm_mem_write_done, svm_fin_valid}), 32'd0);
    tick();
    rst = 0;
    model_count = 0;
    exp_to = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation hung");
    $fatal(1, "hang");
  end

  initial begin
    tick();
    do_reset();
    do_load(NROWS - 1);
    for (int i = 0; i < 4; i++) begin
      issue(1'($urandom_range(1)));
      respond($urandom_range(15), 0, 0);
    end
    issue(1);
    respond(3, 10, 0);
    chk("count_after_hold", 32'(res_count), 32'(model_count));
    // stray result pulse while idle must be ignored
    svm_dout_valid = 1;
    svm_valence = 1;
    tick();
    svm_dout_valid = 0;
    svm_valence = 0;
    @(negedge clk);
    chk("stray_res_valid", 32'(res_valid), 32'd0);
    chk("stray_res_count", 32'(res_count), 32'(model_count));
    tick();
    do_reset();
    do_load(100);
    stall_en = 0;
    issue(0);
    respond(60, 0, 1);
    stall_en = 1;
    issue(0);
    repeat (5) tick();
    do_reset();
    do_load(NROWS - 1);
    issue(0);
    respond(2, 0, 0);
    chk("feat_q_empty", 32'(exp_feat_q.size()), 32'd0);
    chk("res_q_empty", 32'(exp_res_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/svm_ctrl.md
# svm_ctrl

Sequencing controller for the SVM valence/arousal classifier. It runs the one-time SRAM/intercept load phase and orders the two per-inference feature vectors (valence first, then arousal) into the shared SVM datapath. It also captures the single-cycle SVM result pulse into a held, handshaked output and flags protocol errors and hangs. It sits between the host/feature-extraction front end and the SVM core; support, alpha and intercept data buses route directly to the SVM, so this block drives only the control signals.

## Interface
- NBITS, 9: feature quantization width.
- F_WIDTH, 214: features per vector; SVM memory row count.
- NROWS, 214: number of memory rows the load phase must write (addresses 0..NROWS-1, NROWS ≤ 256).
- TIMEOUT, 65535: max cycles from arousal issue to SVM dout_valid.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cfg_valid  in  1  host config beat valid.
- cfg_ready  out  1  config beat accepted when cfg_valid && cfg_ready.
- cfg_icpt  in  1  beat carries intercepts, not a memory row.
- cfg_last  in  1  final config beat.
- svm_mem_write_ready  in  1  SVM is in its SRAM-write state.
- svm_mem_we  out  1  SVM memory write strobe.
- svm_mem_write_addr  out  8  SVM memory row address.
- svm_intercept_valid  out  1  SVM intercept capture strobe.
- svm_mem_write_done  out  1  one-cycle pulse that ends the SVM load phase.
- v_feat_valid / v_feat_ready  in/out  1  valence feature handshake.
- v_feat_data  in  NBITS*F_WIDTH  valence features.
- a_feat_valid / a_feat_ready  in/out  1  arousal feature handshake.
- a_feat_data  in  NBITS*F_WIDTH  arousal features.
- svm_fin_valid  out  1; svm_fin_ready  in  1; svm_features  out  NBITS*F_WIDTH: muxed SVM feature port.
- svm_dout_valid, svm_valence, svm_arousal  in  1  SVM result pulse and bits.
- res_valid  out  1; res_ready  in  1; res_valence, res_arousal  out  1: held result.
- res_count  out  16  completed inferences, wraps.
- busy  out  1  high in any state except V_ISSUE.
- cfg_err  out  1  sticky: row count mismatch at cfg_last.
- timeout_err  out  1  sticky: watchdog expired.

## Operation
- States: LOAD, DONE, V_ISSUE, A_ISSUE, WAIT_RES, OUT. Reset enters LOAD.
- **LOAD**
  - cfg_ready = svm_mem_write_ready.
  - On a fire with !cfg_icpt: svm_mem_we=1 and svm_mem_write_addr=row_cnt, both combinational in the fire cycle. row_cnt then increments.
  - On a fire with cfg_icpt: svm_intercept_valid=1 combinationally; row_cnt is unchanged.
  - Rows written after row_cnt reaches NROWS are still strobed. The address wraps at 8 bits.
  - On a cfg_last fire: if rows written (including this beat) ≠ NROWS, set cfg_err. The block proceeds regardless and goes to DONE.
- **DONE**: svm_mem_write_done=1 for exactly one cycle, then go to V_ISSUE.
- **V_ISSUE**
  - svm_fin_valid=v_feat_valid, svm_features=v_feat_data, v_feat_ready=svm_fin_ready.
  - a_feat_ready=0.
  - On fire, go to A_ISSUE.
- **A_ISSUE**: same as V_ISSUE with the a_* signals. On fire, clear the watchdog and go to WAIT_RES.
- **WAIT_RES**
  - Watchdog increments each cycle.
  - On svm_dout_valid: latch svm_valence and svm_arousal, set res_valid, increment res_count, go to OUT.
  - If the watchdog reaches TIMEOUT first: set timeout_err and remain in WAIT_RES. A late dout_valid is still accepted.
- **OUT**: hold the result. On res_valid && res_ready: clear res_valid and go to V_ISSUE.
- In states other than LOAD, cfg_ready=0. svm_fin_valid=0 outside V_ISSUE/A_ISSUE.
- While a feature port is not selected, its ready must be 0. svm_features is 0 when no port is selected.
- A svm_dout_valid outside WAIT_RES is ignored and does not update results.

## Timing
- Reset values:
  - All strobes/valids 0 and res_valence=res_arousal=0.
  - res_count=0, row_cnt=0, cfg_err=timeout_err=0, busy=1.
  - svm_mem_write_addr=0.
- Reset mid-operation returns to LOAD immediately. The SVM is reset alongside; no state survives.
- Config strobes have zero latency: the SVM samples them on the same edge as the cfg fire.
- A cfg_last fire in cycle t puts svm_mem_write_done high in cycle t+1 and v_feat_ready can rise in cycle t+2.
- Feature handshakes pass straight through with zero added latency; the ready→valid path is combinational.
- res_valid rises the cycle after svm_dout_valid is sampled.
- With res_ready held high, res_valid lasts one cycle. The next v_feat_ready can be high the following cycle.
- Arousal is never issued before valence in the same inference. An a_feat_valid that arrives first waits.

## Test plan
- Load 1 intercept beat plus 214 rows (cfg_last on row 213):
  - writes go to addresses 0..213 with one svm_mem_we each;
  - exactly one intercept_valid;
  - svm_mem_write_done pulses once;
  - cfg_err=0.
- Load with cfg_last on row 100 → cfg_err=1, and the block still reaches V_ISSUE.
- Assert a_feat_valid before v_feat_valid → a_feat_ready stays 0 until the valence fire, then the arousal fire is passed through.
- SVM model returns dout_valid with valence=1, arousal=0 while res_ready=0 for 10 cycles → result held for those 10 cycles; v_feat_ready=0; then res_count=1.
- With TIMEOUT=50, the model never responds → timeout_err=1 at cycle 50 after the arousal fire. A dout_valid at cycle 60 still produces res_valid.
- Assert rst during WAIT_RES → the next cycle is in LOAD with all outputs at reset values and res_count=0.
